// File: rtl/bcd_segment_counter.sv
// Prescaled BCD digit counter with registered seven-segment encoding.
// Define SEVSEG_COMMON_ANODE_EN for active-low (common-anode) segment drive.
module bcd_segment_counter #(
  parameter int          COMPARE_W       = 24,
  parameter int unsigned COMPARE_DEFAULT = 1000
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 enable_i,
  input  logic                 clear_i,
  input  logic                 compare_load_i,
  input  logic [COMPARE_W-1:0] compare_i,
  output logic [3:0]           digit_o,
  output logic                 tick_o,
  output logic                 carry_o,
  output logic [6:0]           segments_o,
  output logic [6:0]           oeb_o
);

  localparam logic [COMPARE_W-1:0] CMP_RST = COMPARE_W'(COMPARE_DEFAULT);

`ifdef SEVSEG_COMMON_ANODE_EN
  localparam logic SEG_INVERT = 1'b1;
`else
  localparam logic SEG_INVERT = 1'b0;
`endif

  localparam logic [6:0] SEG_RST = SEG_INVERT ? 7'b1000000 : 7'b0111111;

  logic [COMPARE_W-1:0] cmp_reg, cmp_next;
  logic [COMPARE_W-1:0] pcnt_reg, pcnt_next;
  logic [COMPARE_W-1:0] period_m1;
  logic [3:0]           digit_reg, digit_next;
  logic                 tick_reg, tick_next;
  logic                 carry_reg, carry_next;
  logic [6:0]           seg_reg, seg_next, seg_raw;

  // A compare value of zero behaves like one: terminal count is then 0.
  assign period_m1 = (cmp_reg == '0) ? '0 : cmp_reg - COMPARE_W'(1);

  always_comb begin
    cmp_next   = cmp_reg;
    pcnt_next  = pcnt_reg;
    digit_next = digit_reg;
    tick_next  = 1'b0;
    carry_next = 1'b0;
    if (clear_i) begin
      pcnt_next  = '0;
      digit_next = 4'd0;
      if (compare_load_i) begin
        cmp_next = compare_i;
      end
    end else if (compare_load_i) begin
      cmp_next  = compare_i;
      pcnt_next = '0;
    end else if (enable_i) begin
      if (pcnt_reg == period_m1) begin
        pcnt_next  = '0;
        tick_next  = 1'b1;
        carry_next = (digit_reg == 4'd9);
        digit_next = (digit_reg == 4'd9) ? 4'd0 : digit_reg + 4'd1;
      end else begin
        pcnt_next = pcnt_reg + COMPARE_W'(1);
      end
    end
  end

  always_comb begin
    case (digit_reg)
      4'd0:    seg_raw = 7'b0111111;
      4'd1:    seg_raw = 7'b0000110;
      4'd2:    seg_raw = 7'b1011011;
      4'd3:    seg_raw = 7'b1001111;
      4'd4:    seg_raw = 7'b1100110;
      4'd5:    seg_raw = 7'b1101101;
      4'd6:    seg_raw = 7'b1111100;
      4'd7:    seg_raw = 7'b0000111;
      4'd8:    seg_raw = 7'b1111111;
      4'd9:    seg_raw = 7'b1100111;
      default: seg_raw = 7'b0000000;
    endcase
  end

  for (genvar gi = 0; gi < 7; gi++) begin : g_seg_pol
    assign seg_next[gi] = seg_raw[gi] ^ SEG_INVERT;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cmp_reg   <= CMP_RST;
      pcnt_reg  <= '0;
      digit_reg <= 4'd0;
      tick_reg  <= 1'b0;
      carry_reg <= 1'b0;
      seg_reg   <= SEG_RST;
    end else begin
      cmp_reg   <= cmp_next;
      pcnt_reg  <= pcnt_next;
      digit_reg <= digit_next;
      tick_reg  <= tick_next;
      carry_reg <= carry_next;
      seg_reg   <= seg_next;
    end
  end

  assign digit_o    = digit_reg;
  assign tick_o     = tick_reg;
  assign carry_o    = carry_reg;
  assign segments_o = seg_reg;
  assign oeb_o      = 7'b0000000;

endmodule

// File: doc/bcd_segment_counter.md
Name: bcd_segment_counter

Overview:
- Upstream digit source and encoder for the user-project seven-segment display on mprj_io[14:8].
- A programmable prescaler divides wb_clk_i into a count tick.
- Each tick advances a BCD digit 0..9 with wrap and carry.
- The digit is encoded to registered 7-segment drive for the IO pads.

Parameters:
COMPARE_W, 24, prescaler counter and compare register width in bits.
COMPARE_DEFAULT, 1000, compare value loaded at reset; ticks occur every COMPARE_DEFAULT cycles.

Ports:
wb_clk_i  input  1  single system clock; all logic on its rising edge.
wb_rst_i  input  1  asynchronous, active-high reset.
enable_i  input  1  prescaler and digit advance enabled while high; state frozen while low.
clear_i  input  1  synchronous clear of prescaler and digit.
compare_load_i  input  1  one-cycle strobe to load compare_i into the compare register.
compare_i  input  COMPARE_W  new prescaler period in cycles.
digit_o  output  4  current BCD digit, 0..9.
tick_o  output  1  one-cycle pulse when the digit advances.
carry_o  output  1  one-cycle pulse when the digit wraps 9 -> 0.
segments_o  output  7  segment drive; bit0 = a ... bit6 = g.
oeb_o  output  7  pad output-enable-bar; constant 0 (outputs driven).

Behaviour:
- Reset (async assert, sync release): cmp = COMPARE_DEFAULT, pcnt = 0, digit_o = 0, tick_o = 0, carry_o = 0, segments_o = 7'b0111111.
- Effective period: P = (cmp == 0) ? 1 : cmp. A compare value of 0 behaves as 1, i.e. a tick every enabled cycle.
- Priority at each edge: clear_i > compare_load_i > normal count.
- clear_i: pcnt <= 0, digit <= 0, tick_o <= 0, carry_o <= 0. The compare register is unaffected unless compare_load_i is also high, in which case the load also happens.
- compare_load_i: cmp <= compare_i, pcnt <= 0, tick_o <= 0, carry_o <= 0. The digit is held. The new period takes effect from the next cycle.
- Normal count, enable_i high:
  - If pcnt == P-1: pcnt <= 0, tick_o <= 1, digit <= (digit == 9) ? 0 : digit+1, carry_o <= (digit == 9).
  - Otherwise: pcnt <= pcnt+1, tick_o <= 0, carry_o <= 0.
- enable_i low: pcnt and digit hold; tick_o <= 0, carry_o <= 0.
- Timing:
  - tick_o and carry_o are high in the same cycle that digit_o first shows the new value.
  - First tick after reset release with enable_i high: after exactly P rising edges.
- Segment encoding:
  - segments_o is registered from digit_o: 1-cycle latency after a digit_o change.
  - Table: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111100, 7=0000111, 8=1111111, 9=1100111.
  - Any digit value 10..15 (unreachable) encodes 0000000.
- Wrap: pcnt never exceeds P-1. If cmp is loaded smaller than the current pcnt, this is safe because pcnt is zeroed on load.
- Reset mid-operation: all state returns to reset values immediately, with no wait for a clock edge.

Optional Feature:
- Macro: SEVSEG_COMMON_ANODE_EN.
- Defined: the segments_o register input is bitwise inverted, for an active-low common-anode display. The reset value becomes 7'b1000000 and unreachable digits encode 1111111.
- Not defined: active-high segments exactly as tabulated.
- All other outputs are identical in both builds.

Test Plan:
- Reset with COMPARE_DEFAULT = 4, enable_i = 1 -> tick_o pulses on edges 4, 8, 12... after release. digit_o = 1, 2, 3 at those pulses. segments_o = 0000110 one cycle after the first tick.
- Load compare_i = 1, run 10 ticks from digit 0 -> segments_o sequences through all ten table codes. carry_o is high only on the 9 -> 0 transition, with digit_o = 0 in that cycle.
- Load compare_i = 0 -> tick every enabled cycle. digit_o increments each cycle, 0..9, 0...
- With P = 5 and pcnt = 3, drop enable_i for 7 cycles then raise it -> the next tick arrives 1 cycle after re-enable, and the digit is unchanged during the pause.
- Assert clear_i and compare_load_i (compare_i = 3) together at digit 7 -> next cycle digit_o = 0, segments_o = 0111111 one cycle later, and the following tick arrives 3 cycles after.
- Assert wb_rst_i asynchronously mid-period at digit 5 -> digit_o = 0 and segments_o = 0111111 (1000000 with SEVSEG_COMMON_ANODE_EN) before the next clock edge.
